kgp_pc_sequencer: RTL and testbench
===================================

# kgp_pc_sequencer

Multi-cycle program-counter sequencer for the next KGP-RISC core. It replaces the single-cycle PC / branch-mux chain with a registered fetch/execute state machine. The state machine uses a request/acknowledge instruction-memory port, a latched flag register, and a hardware return-address stack (RAS) of configurable depth for call/ret. It sits between the instruction memory and the decode/ALU datapath, and owns the architectural PC.

## Interface
Parameters:
- ADDR_W, 32, PC / instruction-address width
- RAS_DEPTH, 8, return-address stack entries (≥2, power of two)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  fetch address; equals pc
- imem_ack  in  1  instruction-memory accepts and returns the word this cycle
- instr_valid  out  1  one-cycle pulse: fetched instruction is valid for decode
- exec_done  in  1  datapath has finished executing the current instruction
- br_type  in  4  control-flow class of the current instruction, sampled on exec_done
- br_offset  in  ADDR_W  sign-extended branch displacement
- br_reg  in  ADDR_W  register target for `br`
- flags_we  in  1  write flags_in into the flag register
- flags_in  in  4  {v,s,c,z} from the ALU
- flags  out  4  latched {v,s,c,z}
- pc  out  ADDR_W  architectural PC
- halted  out  1  sequencer stopped on a RAS fault
- ras_err  out  2  sticky fault code: 01 overflow, 10 underflow

## Operation
br_type encoding:
- 0 none
- 1 b
- 2 br
- 3 bz
- 4 bnz
- 5 bcy
- 6 bncy
- 7 bs
- 8 bns
- 9 bv
- 10 bnv
- 11 call
- 12 ret
- 13–15: treated as none

States: S_IDLE, S_FETCH, S_EXEC, S_HALT. Reset state is S_IDLE.
- S_IDLE: go to S_FETCH after one cycle.
- S_FETCH: imem_req=1, imem_addr=pc. On imem_ack, go to S_EXEC and pulse instr_valid on the first S_EXEC cycle. exec_done is ignored in this state.
- S_EXEC: imem_req=0 and imem_ack is ignored. On exec_done, load pc with pc_next and return to S_FETCH.
- S_HALT: entered on a RAS fault. imem_req=0 and pc is frozen. Only reset leaves this state.

Next-PC rules (all arithmetic modulo 2^ADDR_W; wrap-around silent):
- seq = pc+1; tgt = pc+1+br_offset.
- Conditional branches (3–10) take tgt if the condition holds, else seq.
- Condition flags are forwarded: when flags_we=1 in the exec_done cycle, use flags_in; otherwise use the flags register.
- b takes tgt; br takes br_reg.
- call: pushes seq onto the RAS and takes tgt.
- ret: pops the RAS into pc.
- call with RAS full: no push, pc unchanged, ras_err=01, go to S_HALT.
- ret with RAS empty: pc unchanged, ras_err=10, go to S_HALT.
- Flag register: updated whenever flags_we=1, in any state except S_HALT.

Reset values (asynchronous):
- pc=RESET_PC
- imem_req=0, instr_valid=0
- flags=0
- halted=0, ras_err=00
- RAS pointer=0 (empty)

## Timing
- Minimum 2 cycles per instruction: ack in the S_FETCH cycle, exec_done in the instr_valid cycle.
- imem_req stays high from S_FETCH entry until the ack cycle inclusive. It deasserts the cycle after ack.
- pc and imem_addr change only on the clock edge that consumes exec_done.
- The RAS push/pop commits on the same edge as the pc update.
- halted and ras_err assert on the edge after the faulting exec_done.
- Reset asserted mid-fetch or mid-exec forces reset values immediately. Any pending ack or exec_done is discarded.

## Structure
- Package kgp_seq_pkg holds:
  - br_type localparams (BR_NONE…BR_RET)
  - flag bit indices (FLG_Z=0, FLG_C=1, FLG_S=2, FLG_V=3)
  - state encoding
  - ras_err codes
- Sub-module kgp_ras (parameters ADDR_W, RAS_DEPTH):
  - push, pop, push_data, top, full, empty
  - Pointer of width $clog2(RAS_DEPTH)+1
  - Asynchronous reset empties the stack; entry contents are don't-care.

## Test plan
- Reset, then ack held high, exec_done high with br_type=0: imem_addr goes 0,1,2 on successive S_FETCH cycles; instr_valid pulses every 2nd cycle.
- pc=5, bz, br_offset=-3: with flags_we=1 and flags_in z=1 in the exec_done cycle, next pc=3. Same instruction with latched z=0 and flags_we=0 gives next pc=6.
- pc=10, call offset=+20 → pc=31 and RAS top=11; then ret → pc=11 and RAS empty.
- RAS_DEPTH=4: five nested calls → fifth call leaves pc unchanged, ras_err=01, halted=1, imem_req stays 0.
- ret on empty RAS → ras_err=10, halted=1. Asserting reset clears both and restarts fetch at RESET_PC.
- ADDR_W=8: pc=0xFF, b offset=+1 → pc=0x01 (wraps). Reset asserted while imem_req=1 drops imem_req to 0 asynchronously.

Source files
------------

// File: rtl/kgp_seq_pkg.sv
// Shared constants for the KGP-RISC PC sequencer: branch classes,
// flag bit positions, FSM state encoding, RAS fault codes and condition helpers.
package kgp_seq_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BR   = 4'd2;
  localparam logic [3:0] BR_BZ   = 4'd3;
  localparam logic [3:0] BR_BNZ  = 4'd4;
  localparam logic [3:0] BR_BCY  = 4'd5;
  localparam logic [3:0] BR_BNCY = 4'd6;
  localparam logic [3:0] BR_BS   = 4'd7;
  localparam logic [3:0] BR_BNS  = 4'd8;
  localparam logic [3:0] BR_BV   = 4'd9;
  localparam logic [3:0] BR_BNV  = 4'd10;
  localparam logic [3:0] BR_CALL = 4'd11;
  localparam logic [3:0] BR_RET  = 4'd12;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_S = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [1:0] RAS_OK  = 2'b00;
  localparam logic [1:0] RAS_OVF = 2'b01;
  localparam logic [1:0] RAS_UNF = 2'b10;

  function automatic logic is_cond(input logic [3:0] bt);
    return (bt >= BR_BZ) && (bt <= BR_BNV);
  endfunction

  function automatic logic cond_met(input logic [3:0] bt,
                                    input logic [3:0] f);
    logic r;
    r = 1'b0;
    case (bt)
      BR_BZ:   r =  f[FLG_Z];
      BR_BNZ:  r = !f[FLG_Z];
      BR_BCY:  r =  f[FLG_C];
      BR_BNCY: r = !f[FLG_C];
      BR_BS:   r =  f[FLG_S];
      BR_BNS:  r = !f[FLG_S];
      BR_BV:   r =  f[FLG_V];
      BR_BNV:  r = !f[FLG_V];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kgp_pc_sequencer_if.sv
// Instruction-memory request/acknowledge port of the PC sequencer.
// master: sequencer (drives req/addr); slave: memory (drives ack).
interface kgp_pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/kgp_pc_sequencer_ras.sv
// Hardware return-address stack: push/pop, top-of-stack, full/empty.
// Ports: clk, reset, push, pop, push_data in; top, full, empty out.
module kgp_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_d;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [IW-1:0]     top_idx;

  assign full    = (ptr_q == PW'(RAS_DEPTH));
  assign empty   = (ptr_q == '0);
  assign top_idx = ptr_q[IW-1:0] - IW'(1);
  assign top     = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Entries carry no reset; only the pointer defines occupancy.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[ptr_q[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/kgp_pc_sequencer.sv
// Multi-cycle fetch/execute PC sequencer with flag register and RAS.
// Ports: clk/reset, imem (req/addr/ack), exec handshake, branch info, flags, pc, fault status.
module kgp_pc_sequencer
  import kgp_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  kgp_pc_sequencer_if.master  imem,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic [3:0]          br_type,
  input  logic [ADDR_W-1:0]   br_offset,
  input  logic [ADDR_W-1:0]   br_reg,
  input  logic                flags_we,
  input  logic [3:0]          flags_in,
  output logic [3:0]          flags,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic [1:0]          ras_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        flags_q, flags_d;
  logic              halted_q, halted_d;
  logic [1:0]        ras_err_q, ras_err_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;

  logic [ADDR_W-1:0] seq, tgt;
  logic [3:0]        flg_eff;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full, ras_empty;

  kgp_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign seq = pc_q + ADDR_W'(1);
  assign tgt = seq + br_offset;
  // Flags written alongside exec_done steer that same branch.
  assign flg_eff = flags_we ? flags_in : flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      flags_q       <= '0;
      halted_q      <= 1'b0;
      ras_err_q     <= RAS_OK;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flags_q       <= flags_d;
      halted_q      <= halted_d;
      ras_err_q     <= ras_err_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    ras_err_d = ras_err_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    flags_d   = flags_q;
    if (flags_we && state_q != S_HALT) begin
      flags_d = flags_in;
    end
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_FETCH;
          unique case (1'b1)
            br_type == BR_B:  pc_d = tgt;
            br_type == BR_BR: pc_d = br_reg;
            is_cond(br_type): pc_d = cond_met(br_type, flg_eff) ? tgt : seq;
            br_type == BR_CALL: begin
              if (ras_full) begin
                state_d   = S_HALT;
                halted_d  = 1'b1;
                ras_err_d = RAS_OVF;
              end else begin
                ras_push = 1'b1;
                pc_d     = tgt;
              end
            end
            br_type == BR_RET: begin
              if (ras_empty) begin
                state_d   = S_HALT;
                halted_d  = 1'b1;
                ras_err_d = RAS_UNF;
              end else begin
                ras_pop = 1'b1;
                pc_d    = ras_top;
              end
            end
            default: pc_d = seq;
          endcase
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Request is registered: high for every cycle spent in S_FETCH.
  always_comb begin
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_q == S_FETCH) && imem.imem_ack;
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = instr_valid_q;
  assign flags          = flags_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign ras_err        = ras_err_q;

endmodule

// File: tb/tb_kgp_pc_sequencer.sv
// Scoreboard bench for kgp_pc_sequencer (ADDR_W=8, RAS_DEPTH=4).
// Fetch addresses are queued on ack and checked by a separate monitor.
module tb_kgp_pc_sequencer;
  import kgp_seq_pkg::*;

  localparam int AW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          exec_done;
  logic [3:0]    br_type;
  logic [AW-1:0] br_offset;
  logic [AW-1:0] br_reg;
  logic          flags_we;
  logic [3:0]    flags_in;
  logic [3:0]    flags;
  logic [AW-1:0] pc;
  logic          halted;
  logic [1:0]    ras_err;

  int n_run  = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] exp_pc;

  always #5 clk = ~clk;

  kgp_pc_sequencer_if #(.ADDR_W(AW)) imem ();

  kgp_pc_sequencer #(
    .ADDR_W    (AW),
    .RAS_DEPTH (D),
    .RESET_PC  (8'h00)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .br_type     (br_type),
    .br_offset   (br_offset),
    .br_reg      (br_reg),
    .flags_we    (flags_we),
    .flags_in    (flags_in),
    .flags       (flags),
    .pc          (pc),
    .halted      (halted),
    .ras_err     (ras_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && imem.imem_req && imem.imem_ack) begin
      if (exp_q.size() == 0) begin
        chk("fetch_unexpected", {24'h0, imem.imem_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("fetch_addr", {24'h0, imem.imem_addr}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_fetch(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem.imem_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_instr(input logic [3:0] bt, input logic [AW-1:0] off,
                          input logic [AW-1:0] breg, input logic fwe,
                          input logic [3:0] fin, input logic [AW-1:0] nxt,
                          input logic fault, input logic [1:0] err);
    logic ok;
    wait_fetch(ok);
    if (!ok) return;
    chk("iv_low_in_fetch", {31'h0, instr_valid}, 32'd0);
    exp_q.push_back(exp_pc);
    imem.imem_ack = 1'b1;
    @(posedge clk);
    #1;
    imem.imem_ack = 1'b0;
    chk("instr_valid", {31'h0, instr_valid}, 32'd1);
    chk("req_drop", {31'h0, imem.imem_req}, 32'd0);
    exec_done = 1'b1;
    br_type   = bt;
    br_offset = off;
    br_reg    = breg;
    flags_we  = fwe;
    flags_in  = fin;
    @(posedge clk);
    #1;
    exec_done = 1'b0;
    br_type   = BR_NONE;
    flags_we  = 1'b0;
    if (fault) begin
      chk("halted", {31'h0, halted}, 32'd1);
      chk("ras_err", {30'h0, ras_err}, {30'h0, err});
      chk("pc_frozen", {24'h0, pc}, {24'h0, exp_pc});
      chk("req_halt", {31'h0, imem.imem_req}, 32'd0);
    end else begin
      chk("pc_next", {24'h0, pc}, {24'h0, nxt});
      exp_pc = nxt;
    end
  endtask

  task automatic pulse_reset_check();
    reset = 1'b1;
    #1;
    chk("rst_pc", {24'h0, pc}, 32'd0);
    chk("rst_req", {31'h0, imem.imem_req}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_err", {30'h0, ras_err}, 32'd0);
    chk("rst_flags", {28'h0, flags}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_pc = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    imem.imem_ack = 1'b0;
    exec_done = 1'b0;
    br_type   = BR_NONE;
    br_offset = '0;
    br_reg    = '0;
    flags_we  = 1'b0;
    flags_in  = '0;
    exp_pc    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset_check();

    for (int i = 1; i <= 5; i++) begin
      do_instr(BR_NONE, 8'h00, 8'h00, 1'b0, 4'h0, AW'(i), 1'b0, RAS_OK);
    end
    do_instr(BR_BZ, 8'hFD, 8'h00, 1'b1, 4'b0001, 8'd3, 1'b0, RAS_OK);
    chk("flags_z", {28'h0, flags}, 32'h1);
    do_instr(BR_NONE, 8'h00, 8'h00, 1'b1, 4'b0000, 8'd4, 1'b0, RAS_OK);
    do_instr(BR_NONE, 8'h00, 8'h00, 1'b0, 4'b0000, 8'd5, 1'b0, RAS_OK);
    do_instr(BR_BZ, 8'hFD, 8'h00, 1'b0, 4'b0001, 8'd6, 1'b0, RAS_OK);
    do_instr(BR_BCY, 8'd2, 8'h00, 1'b1, 4'b0010, 8'd9, 1'b0, RAS_OK);
    do_instr(BR_BNCY, 8'd5, 8'h00, 1'b0, 4'b0000, 8'd10, 1'b0, RAS_OK);
    chk("flags_c", {28'h0, flags}, 32'h2);

    do_instr(BR_CALL, 8'd20, 8'h00, 1'b0, 4'h0, 8'd31, 1'b0, RAS_OK);
    chk("ras_top", {24'h0, u_dut.ras_top}, 32'd11);
    do_instr(BR_RET, 8'd0, 8'h00, 1'b0, 4'h0, 8'd11, 1'b0, RAS_OK);
    chk("ras_empty", {31'h0, u_dut.ras_empty}, 32'd1);
    do_instr(BR_BR, 8'd0, 8'd40, 1'b0, 4'h0, 8'd40, 1'b0, RAS_OK);

    do_instr(BR_CALL, 8'd0, 8'h00, 1'b0, 4'h0, 8'd41, 1'b0, RAS_OK);
    do_instr(BR_CALL, 8'd0, 8'h00, 1'b0, 4'h0, 8'd42, 1'b0, RAS_OK);
    do_instr(BR_CALL, 8'd0, 8'h00, 1'b0, 4'h0, 8'd43, 1'b0, RAS_OK);
    do_instr(BR_CALL, 8'd0, 8'h00, 1'b0, 4'h0, 8'd44, 1'b0, RAS_OK);
    do_instr(BR_CALL, 8'd0, 8'h00, 1'b0, 4'h0, 8'd0, 1'b1, RAS_OVF);
    flags_we = 1'b1;
    flags_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("halt_req", {31'h0, imem.imem_req}, 32'd0);
      chk("halt_pc", {24'h0, pc}, 32'd44);
      chk("halt_flags", {28'h0, flags}, 32'h2);
    end
    flags_we = 1'b0;
    pulse_reset_check();

    do_instr(BR_RET, 8'd0, 8'h00, 1'b0, 4'h0, 8'd0, 1'b1, RAS_UNF);
    pulse_reset_check();

    do_instr(BR_B, 8'hFD, 8'h00, 1'b0, 4'h0, 8'hFE, 1'b0, RAS_OK);
    do_instr(BR_NONE, 8'h00, 8'h00, 1'b0, 4'h0, 8'hFF, 1'b0, RAS_OK);
    do_instr(BR_B, 8'h01, 8'h00, 1'b0, 4'h0, 8'h01, 1'b0, RAS_OK);

    begin
      logic ok;
      wait_fetch(ok);
      #2;
      reset = 1'b1;
      #1;
      chk("async_req", {31'h0, imem.imem_req}, 32'd0);
      chk("async_pc", {24'h0, pc}, 32'd0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      exp_pc = 8'h00;
    end
    do_instr(BR_NONE, 8'h00, 8'h00, 1'b0, 4'h0, 8'h01, 1'b0, RAS_OK);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
